// File: rtl/id_ex_stage_pkg.sv
// Shared control-word layout and constants for the ID/EX pipeline stage.
package id_ex_stage_pkg;

  // Control word layout: {regWrite, memRead, memWrite, memToReg, aluSrc, aluOp[2:0]}
  localparam int unsigned CTRL_W        = 8;
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMREAD  = 6;
  localparam int unsigned CTRL_MEMWRITE = 5;
  localparam int unsigned CTRL_MEMTOREG = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_ALUOP    = 0;
  localparam int unsigned CTRL_ALUOP_W  = 3;

  // A bubble is an all-zero control word: no write, no memory access.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  // Width of the saturating bubble counter.
  localparam int unsigned BCNT_W = 16;

  // True when the control word describes a load.
  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Operand bypass select: EX/MEM beats MEM/WB beats the register-file value.
module forward_mux #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] regValue,
  input  logic          exMemRegWrite,
  input  logic [AW-1:0] exMemRd,
  input  logic [DW-1:0] exMemData,
  input  logic          memWbRegWrite,
  input  logic [AW-1:0] memWbRd,
  input  logic [DW-1:0] memWbData,
  output logic [DW-1:0] fwd
);

  // Priority select; a zero destination index never matches, so r0 is never bypassed.
  always_comb begin
    fwd = regValue;
    if (exMemRegWrite && (exMemRd != '0) && (exMemRd == index)) begin
      fwd = exMemData;
    end else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == index)) begin
      fwd = memWbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// saturating bubble counter and EX-operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     R1,
  input  logic [DW-1:0]     R2,
  input  logic [AW-1:0]     R1point,
  input  logic [AW-1:0]     R2point,
  input  logic [AW-1:0]     idRd,
  input  logic [DW-1:0]     idImm,
  input  logic [CTRL_W-1:0] idCtrl,
  input  logic              flush,
  input  logic              exMemRegWrite,
  input  logic [AW-1:0]     exMemRd,
  input  logic [DW-1:0]     exMemData,
  input  logic              memWbRegWrite,
  input  logic [AW-1:0]     memWbRd,
  input  logic [DW-1:0]     memWbData,
  output logic              stall,
  output logic [AW-1:0]     exRs,
  output logic [AW-1:0]     exRt,
  output logic [AW-1:0]     exRd,
  output logic [DW-1:0]     exImm,
  output logic [CTRL_W-1:0] exCtrl,
  output logic [DW-1:0]     fwdA,
  output logic [DW-1:0]     fwdB,
  output logic [BCNT_W-1:0] bubbleCount
);

  logic [DW-1:0]     r_r1;
  logic [DW-1:0]     r_r2;
  logic [AW-1:0]     r_rs;
  logic [AW-1:0]     r_rt;
  logic [AW-1:0]     r_rd;
  logic [DW-1:0]     r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [BCNT_W-1:0] r_bubble_count;

  logic              w_hazard;
  logic              w_bubble;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    w_hazard = ctrl_is_load(r_ctrl) && (r_rd != '0) &&
               ((r_rd == R1point) || (r_rd == R2point));
    w_bubble = w_hazard || flush;
  end

  // EX pipeline registers; a bubble zeroes control and destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1   <= '0;
      r_r2   <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_imm  <= '0;
      r_ctrl <= BUBBLE_CTRL;
    end else begin
      r_r1  <= R1;
      r_r2  <= R2;
      r_rs  <= R1point;
      r_rt  <= R2point;
      r_imm <= idImm;
      if (w_bubble) begin
        r_rd   <= '0;
        r_ctrl <= BUBBLE_CTRL;
      end else begin
        r_rd   <= idRd;
        r_ctrl <= idCtrl;
      end
    end
  end

  // Saturating count of bubbles loaded into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
    end else if (w_bubble && (r_bubble_count != '1)) begin
      r_bubble_count <= r_bubble_count + BCNT_W'(1);
    end
  end

  forward_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .index         (r_rs),
    .regValue      (r_r1),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemData     (exMemData),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbData     (memWbData),
    .fwd           (fwdA)
  );

  forward_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .index         (r_rt),
    .regValue      (r_r2),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemData     (exMemData),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbData     (memWbData),
    .fwd           (fwdB)
  );

  assign stall       = w_hazard;
  assign exRs        = r_rs;
  assign exRt        = r_rt;
  assign exRd        = r_rd;
  assign exImm       = r_imm;
  assign exCtrl      = r_ctrl;
  assign bubbleCount = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] R1, R2, idImm, exMemData, memWbData;
  logic [AW-1:0] R1point, R2point, idRd, exMemRd, memWbRd;
  logic [7:0]    idCtrl;
  logic          flush, exMemRegWrite, memWbRegWrite;
  logic          stall;
  logic [AW-1:0] exRs, exRt, exRd;
  logic [DW-1:0] exImm, fwdA, fwdB;
  logic [7:0]    exCtrl;
  logic [15:0]   bubbleCount;

  int checks;
  int failures;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .R1            (R1),
    .R2            (R2),
    .R1point       (R1point),
    .R2point       (R2point),
    .idRd          (idRd),
    .idImm         (idImm),
    .idCtrl        (idCtrl),
    .flush         (flush),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemData     (exMemData),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbData     (memWbData),
    .stall         (stall),
    .exRs          (exRs),
    .exRt          (exRt),
    .exRd          (exRd),
    .exImm         (exImm),
    .exCtrl        (exCtrl),
    .fwdA          (fwdA),
    .fwdB          (fwdB),
    .bubbleCount   (bubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] p1, input logic [4:0] p2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [7:0] ctrl);
    R1 = r1; R2 = r2; R1point = p1; R2point = p2;
    idRd = rd; idImm = imm; idCtrl = ctrl;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    exMemRegWrite = 1'b0; exMemRd = '0; exMemData = '0;
    memWbRegWrite = 1'b0; memWbRd = '0; memWbData = '0;
    drive_id(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);

    // Reset state
    #3;
    chk("rst_exCtrl", 32'(exCtrl), 32'h0);
    chk("rst_exRd", 32'(exRd), 32'h0);
    chk("rst_bubbleCount", 32'(bubbleCount), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // First capture after reset release
    @(negedge clk);
    rst_n = 1'b1;
    drive_id(32'h100, 32'h200, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF0, 8'h88);
    tick();
    chk("cap_exRs", 32'(exRs), 32'd1);
    chk("cap_exRt", 32'(exRt), 32'd2);
    chk("cap_exRd", 32'(exRd), 32'd3);
    chk("cap_exImm", exImm, 32'hFFFF_FFF0);
    chk("cap_exCtrl", 32'(exCtrl), 32'h88);
    chk("cap_fwdA", fwdA, 32'h100);
    chk("cap_fwdB", fwdB, 32'h200);

    // Forwarding priority and r0 exclusion
    drive_id(32'h5555, 32'h1234, 5'd3, 5'd0, 5'd7, 32'h0, 8'h80);
    tick();
    exMemRegWrite = 1'b1; exMemRd = 5'd3; exMemData = 32'hAAAA_0000;
    memWbRegWrite = 1'b1; memWbRd = 5'd3; memWbData = 32'h1111_0000;
    #1;
    chk("fwdA_exmem_prio", fwdA, 32'hAAAA_0000);
    exMemRd = 5'd0;
    #1;
    chk("fwdB_r0_noforward", fwdB, 32'h1234);
    chk("fwdA_memwb", fwdA, 32'h1111_0000);
    memWbRegWrite = 1'b0;
    #1;
    chk("fwdA_regfile", fwdA, 32'h5555);
    exMemRegWrite = 1'b0;

    // No hazard from a non-load in EX
    R1point = 5'd7;
    #1;
    chk("nonload_nostall", 32'(stall), 32'h0);

    // Load-use stall on R1point
    drive_id(32'h0, 32'h0, 5'd2, 5'd0, 5'd5, 32'h4, 8'hD8);
    tick();
    chk("lw_exCtrl", 32'(exCtrl), 32'hD8);
    drive_id(32'h10, 32'h20, 5'd5, 5'd6, 5'd8, 32'h0, 8'h80);
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    tick();
    chk("lu_bubble_ctrl", 32'(exCtrl), 32'h0);
    chk("lu_bubble_rd", 32'(exRd), 32'h0);
    chk("lu_bubbleCount", 32'(bubbleCount), 32'd1);
    chk("lu_stall_clear", 32'(stall), 32'h0);
    tick();
    chk("lu_reissue_ctrl", 32'(exCtrl), 32'h80);
    chk("lu_reissue_rd", 32'(exRd), 32'd8);
    chk("lu_reissue_cnt", 32'(bubbleCount), 32'd1);

    // Load-use on R2point together with flush: single bubble
    drive_id(32'h0, 32'h0, 5'd1, 5'd1, 5'd6, 32'h0, 8'hD8);
    tick();
    drive_id(32'h0, 32'h0, 5'd1, 5'd6, 5'd9, 32'h0, 8'h80);
    flush = 1'b1;
    #1;
    chk("fl_st_stall", 32'(stall), 32'h1);
    tick();
    flush = 1'b0;
    chk("fl_st_ctrl", 32'(exCtrl), 32'h0);
    chk("fl_st_cnt", 32'(bubbleCount), 32'd2);
    chk("fl_st_stall_clear", 32'(stall), 32'h0);

    // Flush alone
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ctrl", 32'(exCtrl), 32'h0);
    chk("flush_cnt", 32'(bubbleCount), 32'd3);

    // fwdB from MEM/WB while fwdA takes EX/MEM
    drive_id(32'h66, 32'h77, 5'd4, 5'd9, 5'd10, 32'h0, 8'h80);
    tick();
    exMemRegWrite = 1'b1; exMemRd = 5'd4; exMemData = 32'h0000_BEEF;
    memWbRegWrite = 1'b1; memWbRd = 5'd9; memWbData = 32'hCAFE_F00D;
    #1;
    chk("fwdA_exmem", fwdA, 32'h0000_BEEF);
    chk("fwdB_memwb", fwdB, 32'hCAFE_F00D);
    exMemRegWrite = 1'b0; memWbRegWrite = 1'b0;

    // Load to r0 never stalls
    drive_id(32'h0, 32'h0, 5'd1, 5'd1, 5'd0, 32'h0, 8'hD8);
    tick();
    drive_id(32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 32'h0, 8'h80);
    #1;
    chk("lw_r0_nostall", 32'(stall), 32'h0);

    // Asynchronous reset mid-run with exCtrl = 0xFF
    drive_id(32'h0, 32'h0, 5'd1, 5'd1, 5'd12, 32'h0, 8'hFF);
    tick();
    chk("pre_rst_exCtrl", 32'(exCtrl), 32'hFF);
    R1point = 5'd12;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exCtrl", 32'(exCtrl), 32'h0);
    chk("mid_rst_exRd", 32'(exRd), 32'h0);
    chk("mid_rst_cnt", 32'(bubbleCount), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_id(32'h9, 32'h8, 5'd13, 5'd14, 5'd15, 32'h3, 8'h81);
    tick();
    chk("post_rst_ctrl", 32'(exCtrl), 32'h81);
    chk("post_rst_rd", 32'(exRd), 32'd15);

    // Drive the bubble counter to saturation
    flush = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_pre", 32'(bubbleCount), 32'hFFFD);
    tick();
    chk("sat_1", 32'(bubbleCount), 32'hFFFE);
    tick();
    chk("sat_2", 32'(bubbleCount), 32'hFFFF);
    tick();
    chk("sat_3_hold", 32'(bubbleCount), 32'hFFFF);
    tick();
    chk("sat_4_hold", 32'(bubbleCount), 32'hFFFF);
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
